wave_gen_core: RTL
==================

# wave_gen_core

Parametrised, pipelined waveform-shaping core for the function generator. It converts a phase stream from the phase accumulator into one of four waveforms: ramp-up, ramp-down, square with programmable duty, or cosine from a quarter-wave table. The output is scaled by a programmable gain. A waveform change requested mid-cycle is deferred to the next phase wrap, so the DAC output stays glitch-free. It sits between the phase accumulator and the DAC driver, and supersedes the fixed 8-bit/10-bit four-ROM selector.

## Interface
- PHASE_W, 8, phase input width; must be ≥ 4.
- AMP_W, 10, amplitude output width; must be ≥ PHASE_W.
- LUT_AW, localparam = PHASE_W-2, quarter-wave table address width; table has 2^LUT_AW+1 entries.
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset (one clock; async active-low fixed).
- in_valid  in  1  phase_in/select/duty/gain are sampled this cycle.
- phase_in  in  PHASE_W  phase, 0..2^PHASE_W-1, wraps.
- select  in  2  requested waveform: 00 ramp-up, 01 ramp-down, 10 square, 11 cosine.
- duty  in  PHASE_W  square high-time threshold.
- gain  in  9  amplitude scale; 256 = unity, values >256 saturate to 256.
- out_valid  out  1  amplitude is valid this cycle.
- amplitude  out  AMP_W  shaped, scaled sample.

## Operation
- Mode register: active_sel, pending_sel, first_flag (set by reset), prev_phase.
- On each accepted sample (in_valid=1):
  - If first_flag=1: active_sel ← select, first_flag ← 0.
  - Else if phase_in < prev_phase (wrap): active_sel ← pending_sel; the wrap sample itself uses the new mode.
  - pending_sel ← select every accepted sample; prev_phase ← phase_in.
  - A request that changes and changes back before a wrap has no effect.
- Shapes, with MAXA = 2^AMP_W-1, MID = 2^(AMP_W-1), S = AMP_W-PHASE_W:
  - Ramp-up: phase << S.
  - Ramp-down: (~phase) << S.
  - Square: MAXA if phase < duty, else 0. duty=0 gives constant 0; duty=2^PHASE_W-1 gives low only at the final phase.
  - Cosine: q = phase[PHASE_W-1:PHASE_W-2], i = phase[LUT_AW-1:0], N = 2^LUT_AW. T[k] = round((MID-1)·cos(π k/(2N))), so T[0] = MID-1 and T[N] = 0.
    - q0: MID+T[i]
    - q1: MID−T[N−i]
    - q2: MID−T[i]
    - q3: MID+T[N−i]
    - For PHASE_W=8/AMP_W=10: phase 0 → 1023, 64 → 512, 128 → 1, 192 → 512.
- Gain: amplitude = (shape · g) >> 8, where g = min(gain, 256). The product is AMP_W+9 bits, with no rounding. Unity gain reproduces shape exactly.
- Idle cycles (in_valid=0) do not advance mode logic and produce out_valid=0. amplitude holds its last value.

## Timing
- 3-stage pipeline, fixed latency 3: a sample accepted at cycle n gives out_valid=1 at n+3.
  - S1: register phase, mode, duty, and clamped gain.
  - S2: table read and shape mux.
  - S3: multiply/shift into the output register.
- Full throughput: one sample per clock, with no backpressure.
- Reset (asserted any time, including mid-pipeline) immediately clears:
  - out_valid=0, amplitude=0
  - pipeline valids, active_sel=00, pending_sel=00, prev_phase=0, first_flag=1
- In-flight samples are discarded. The first sample after reset release appears 3 cycles after acceptance.
- gain and duty take effect per sample, with no wrap deferral.

## Structure
- Package wave_gen_pkg:
  - select encodings (WAVE_RAMP_UP, WAVE_RAMP_DN, WAVE_SQUARE, WAVE_COS)
  - GAIN_UNITY=256
  - a function computing T[k] for given LUT_AW/AMP_W, used for table initialisation
- One sub-module, cos_quarter_lut:
  - synchronous read of the quarter-wave table, address LUT_AW+1 bits, registered output
  - forms the S2 table read

## Test plan
- Reset, then the first sample with select=11, phase 0, gain 256 → out_valid at +3, amplitude 1023. Phases 64/128/192 → 512/1/512.
- Ramp-up, full 0..255 sweep, gain 256 → amplitude = 4·phase, continuous out_valid, latency 3. Gain 128 at phase 200 → 400. Gain 400 → same as 256.
- Square, duty 64 → phases 0..63 give 1023, 64..255 give 0. duty 0 → all 0.
- Running ramp-up, select changed to 01 at phase 100 → ramp-up continues through 255. Phase 0 of the next cycle outputs 1020 (ramp-down). Toggling 01→00 before the wrap → no change.
- Sparse in_valid (1 in 3) → output only for valid samples, each 3 cycles later. prev_phase is unaffected by idle cycles.
- rst_n asserted with 3 samples in flight → out_valid=0 and amplitude=0 immediately. After release, the first sample takes select directly, with no wrap needed.

Source files
------------

// File: rtl/wave_gen_pkg.sv
// Shared definitions for the waveform-shaping core: select encodings, unity gain,
// and the quarter-wave cosine table generator used at elaboration time.
package wave_gen_pkg;

  typedef enum logic [1:0] {
    WAVE_RAMP_UP = 2'b00,
    WAVE_RAMP_DN = 2'b01,
    WAVE_SQUARE  = 2'b10,
    WAVE_COS     = 2'b11
  } wave_sel_e;

  localparam int GAIN_UNITY = 256;
  localparam real PI = 3.14159265358979323846;

  // T[k] = round((MID-1) * cos(pi*k / (2*N))), N = 2^lut_aw, MID = 2^(amp_w-1).
  // The Taylor series keeps the evaluation to plain real arithmetic; 12 terms is
  // far beyond double precision for arguments in [0, pi/2].
  function automatic int cos_entry(input int k, input int lut_aw, input int amp_w);
    real x;
    real term;
    real sum;
    real scaled;
    x    = PI * real'(k) / (2.0 * real'(1 << lut_aw));
    term = 1.0;
    sum  = 1.0;
    for (int n = 1; n <= 12; n++) begin
      term = -term * x * x / real'((2 * n - 1) * (2 * n));
      sum  = sum + term;
    end
    scaled = real'((1 << (amp_w - 1)) - 1) * sum;
    if (scaled < 0.0) scaled = 0.0;
    return $rtoi(scaled + 0.5);
  endfunction

endpackage

// File: rtl/cos_quarter_lut.sv
// Quarter-wave cosine magnitude table, 2^LUT_AW+1 entries, with a registered
// synchronous read port.
module cos_quarter_lut
  import wave_gen_pkg::*;
#(
  parameter int LUT_AW = 6,
  parameter int AMP_W  = 10
) (
  input  logic              clk,
  input  logic [LUT_AW:0]   i_addr,
  output logic [AMP_W-2:0]  o_data
);

  localparam int N = 1 << LUT_AW;

  logic [AMP_W-2:0] w_tab [0:N];
  logic [AMP_W-2:0] r_data;

  for (genvar k = 0; k <= N; k++) begin : g_tab
    assign w_tab[k] = (AMP_W-1)'(cos_entry(k, LUT_AW, AMP_W));
  end

  always_ff @(posedge clk) begin
    r_data <= w_tab[i_addr];
  end

  assign o_data = r_data;

endmodule

// File: rtl/wave_gen_core.sv
// Three-stage waveform shaper: phase -> ramp/square/cosine shape -> gain scaling.
// Waveform changes are deferred to the next phase wrap so the output never glitches.
module wave_gen_core
  import wave_gen_pkg::*;
#(
  parameter int PHASE_W = 8,
  parameter int AMP_W   = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [PHASE_W-1:0] phase_in,
  input  logic [1:0]         select,
  input  logic [PHASE_W-1:0] duty,
  input  logic [8:0]         gain,
  output logic               out_valid,
  output logic [AMP_W-1:0]   amplitude
);

  localparam int LUT_AW = PHASE_W - 2;
  localparam int N      = 1 << LUT_AW;
  localparam int S      = AMP_W - PHASE_W;
  localparam logic [AMP_W-1:0] MAXA = '1;
  localparam logic [AMP_W-1:0] MID  = {1'b1, {(AMP_W-1){1'b0}}};

  function automatic logic [8:0] clamp_gain(input logic [8:0] g);
    return (g > 9'(GAIN_UNITY)) ? 9'(GAIN_UNITY) : g;
  endfunction

  function automatic logic [AMP_W-1:0] scale_gain(input logic [AMP_W-1:0] s,
                                                 input logic [8:0] g);
    logic [AMP_W+8:0] prod;
    prod = {9'b0, s} * {{AMP_W{1'b0}}, g};
    return prod[AMP_W+7:8];
  endfunction

  logic [1:0]         r_active_sel;
  logic [1:0]         r_pending_sel;
  logic               r_first;
  logic [PHASE_W-1:0] r_prev_phase;
  logic [1:0]         w_sel_eff;

  // A wrap sample already uses the deferred request; the very first sample after
  // reset takes its select directly.
  always_comb begin
    w_sel_eff = r_active_sel;
    if (r_first)
      w_sel_eff = select;
    else if (phase_in < r_prev_phase)
      w_sel_eff = r_pending_sel;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_active_sel  <= 2'b00;
      r_pending_sel <= 2'b00;
      r_first       <= 1'b1;
      r_prev_phase  <= '0;
    end else if (in_valid) begin
      r_active_sel  <= w_sel_eff;
      r_pending_sel <= select;
      r_first       <= 1'b0;
      r_prev_phase  <= phase_in;
    end
  end

  // Stage 1: capture phase, resolved mode, duty and clamped gain
  logic               r_vld_p1;
  logic [PHASE_W-1:0] r_phase_p1;
  logic [1:0]         r_sel_p1;
  logic [PHASE_W-1:0] r_duty_p1;
  logic [8:0]         r_gain_p1;

  always_ff @(posedge clk) begin
    if (in_valid) begin
      r_phase_p1 <= phase_in;
      r_sel_p1   <= w_sel_eff;
      r_duty_p1  <= duty;
      r_gain_p1  <= clamp_gain(gain);
    end
  end

  // Stage 2: table read and shape mux
  logic [1:0]         w_quad_p1;
  logic [LUT_AW-1:0]  w_idx_p1;
  logic [LUT_AW:0]    w_addr_p1;
  logic [PHASE_W-1:0] w_inv_p1;
  logic [AMP_W-1:0]   w_shape_p1;
  logic [AMP_W-2:0]   w_lut_p2;

  assign w_quad_p1 = r_phase_p1[PHASE_W-1 -: 2];
  assign w_idx_p1  = r_phase_p1[LUT_AW-1:0];
  assign w_inv_p1  = ~r_phase_p1;
  // Odd quadrants walk the quarter table backwards, which needs index N itself.
  assign w_addr_p1 = w_quad_p1[0] ? ((LUT_AW+1)'(N) - {1'b0, w_idx_p1})
                                  : {1'b0, w_idx_p1};

  cos_quarter_lut #(
    .LUT_AW (LUT_AW),
    .AMP_W  (AMP_W)
  ) u_lut (
    .clk    (clk),
    .i_addr (w_addr_p1),
    .o_data (w_lut_p2)
  );

  always_comb begin
    w_shape_p1 = '0;
    case (r_sel_p1)
      WAVE_RAMP_UP: w_shape_p1 = AMP_W'(r_phase_p1) << S;
      WAVE_RAMP_DN: w_shape_p1 = AMP_W'(w_inv_p1) << S;
      WAVE_SQUARE:  w_shape_p1 = (r_phase_p1 < r_duty_p1) ? MAXA : '0;
      default:      w_shape_p1 = '0;
    endcase
  end

  logic               r_vld_p2;
  logic [AMP_W-1:0]   r_shape_p2;
  logic               r_is_cos_p2;
  logic               r_cos_neg_p2;
  logic [8:0]         r_gain_p2;

  always_ff @(posedge clk) begin
    r_shape_p2   <= w_shape_p1;
    r_is_cos_p2  <= (r_sel_p1 == WAVE_COS);
    r_cos_neg_p2 <= w_quad_p1[1] ^ w_quad_p1[0];
    r_gain_p2    <= r_gain_p1;
  end

  // Stage 3: cosine offset, gain multiply and output register
  logic [AMP_W-1:0] w_cos_p2;
  logic [AMP_W-1:0] w_sample_p2;
  logic             r_vld_p3;
  logic [AMP_W-1:0] r_amp_p3;

  assign w_cos_p2    = r_cos_neg_p2 ? (MID - {1'b0, w_lut_p2}) : (MID + {1'b0, w_lut_p2});
  assign w_sample_p2 = r_is_cos_p2 ? w_cos_p2 : r_shape_p2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p1 <= 1'b0;
      r_vld_p2 <= 1'b0;
      r_vld_p3 <= 1'b0;
      r_amp_p3 <= '0;
    end else begin
      r_vld_p1 <= in_valid;
      r_vld_p2 <= r_vld_p1;
      r_vld_p3 <= r_vld_p2;
      if (r_vld_p2)
        r_amp_p3 <= scale_gain(w_sample_p2, r_gain_p2);
    end
  end

  assign out_valid = r_vld_p3;
  assign amplitude = r_amp_p3;

endmodule
